// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Optional device-response watchdog enabled by defining PS2TX_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | clock held low for INHIBIT_CYCLES, data pulled low in last cycle
// REQ      | clock released, start bit (data low) driven
// SHIFT    | data bits presented LSB first, one per device falling edge
// PARITY   | odd parity bit presented
// STOP     | data released (stop bit), next edge samples device ACK
// ACK      | one-cycle settle after the ACK sample
// WAITIDLE | wait for device to release both lines
// DONE     | one-cycle tx_done pulse
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, INHIBIT, REQ, SHIFT, PARITY, STOP, ACK, WAITIDLE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          err_q, err_d;
  logic          tx_err_q;
  logic          accept;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

`ifdef PS2TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wd_q;
  logic          wd_active;
  logic          wd_expired;

  assign wd_active  = (state_q == REQ) || (state_q == SHIFT) || (state_q == PARITY) ||
                      (state_q == STOP) || (state_q == ACK) || (state_q == WAITIDLE);
  assign wd_expired = wd_active && (wd_q == '0);

  // Reloaded on the way into REQ and on every device edge, so it measures the gap between edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == INHIBIT || fall) begin
      wd_q <= TW'(TIMEOUT_CYCLES - 1);
    end else if (wd_active && wd_q != '0) begin
      wd_q <= wd_q - 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    err_d       = err_q;
    accept      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = IW'(INHIBIT_CYCLES - 1);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == '0) begin
          ps2_data_oe = 1'b1;
          state_d     = REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        if (fall) begin
          bit_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ps2_data_oe = ~data_q[bit_q];
        if (fall) begin
          if (bit_q == 3'd7) state_d = PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        ps2_data_oe = ~parity_q;
        if (fall) state_d = STOP;
      end
      STOP: begin
        if (fall) begin
          err_d   = data_s2;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAITIDLE;
      WAITIDLE: if (clk_s2 && data_s2) state_d = DONE;
      DONE: begin
        tx_done = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
`ifdef PS2TX_TIMEOUT_EN
    if (wd_expired) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      err_d       = 1'b1;
      state_d     = DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
      tx_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      if (accept) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
        tx_err_q <= 1'b0;
      end else if (state_d == DONE) begin
        // Publish the result together with tx_done and hold it until the next accepted start.
        tx_err_q <= err_d;
      end
    end
  end

  assign tx_busy = (state_q != IDLE);
  assign tx_err  = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Timeout scenario runs only when PS2TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;

  logic dev_clk = 1'b1;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      last_err <= tx_err;
    end
  end

  // Observations filled in by the transfer driver
  logic obs [1:11];
  int   inh_len, done_delta;
  logic busy_c1, clk_oe_c1, err_c1, start_oe;
  logic busy_end, clk_oe_end, data_oe_end;
  logic ab_clk_oe, ab_data_oe, ab_busy;

  task automatic xfer(input logic [7:0] d, input logic ack, input int glitch_edge,
                      input int abort_edge);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start  = 1'b0;
    tx_data   = ~d;
    busy_c1   = tx_busy;
    clk_oe_c1 = ps2_clk_oe;
    err_c1    = tx_err;
    inh_len   = 0;
    while (ps2_clk_oe && inh_len < INH + 10) begin
      inh_len++;
      @(negedge clk);
    end
    start_oe = ps2_data_oe;
    repeat (3) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11) begin
        dev_data_low = ack;
        repeat (4) @(negedge clk);
      end
      if (e == glitch_edge) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      obs[e] = ps2_data_oe;
      if (e == abort_edge) begin
        reset = 1'b1;
        @(negedge clk);
        ab_clk_oe  = ps2_clk_oe;
        ab_data_oe = ps2_data_oe;
        ab_busy    = tx_busy;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        done_delta = done_cnt - d0;
        return;
      end
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    dev_data_low = 1'b0;
    repeat (40) @(negedge clk);
    done_delta  = done_cnt - d0;
    busy_end    = tx_busy;
    clk_oe_end  = ps2_clk_oe;
    data_oe_end = ps2_data_oe;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (4) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", tx_done); end
    n_checks++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", tx_err); end
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed;
    logic [1:8] exp_bits;
    exp_bits = 8'b10110111;
    xfer(8'hED, 1'b1, 0, 0);
    n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL ed_busy_cycle1 got %b want 1", busy_c1); end
    n_checks++; if (clk_oe_c1 !== 1'b1) begin n_fail++; $display("FAIL ed_inhibit_cycle1 got %b want 1", clk_oe_c1); end
    n_checks++; if (inh_len != INH) begin n_fail++; $display("FAIL ed_inhibit_len got %0d want %0d", inh_len, INH); end
    n_checks++; if (start_oe !== 1'b1) begin n_fail++; $display("FAIL ed_start_bit data_oe got %b want 1", start_oe); end
    for (int e = 1; e <= 8; e++) begin
      n_checks++;
      if (obs[e] !== ~exp_bits[e]) begin
        n_fail++; $display("FAIL ed_bit edge %0d data_oe got %b want %b", e, obs[e], ~exp_bits[e]);
      end
    end
    n_checks++; if (obs[9] !== 1'b0) begin n_fail++; $display("FAIL ed_parity data_oe got %b want 0", obs[9]); end
    n_checks++; if (obs[10] !== 1'b0) begin n_fail++; $display("FAIL ed_stop data_oe got %b want 0", obs[10]); end
    n_checks++; if (done_delta != 1) begin n_fail++; $display("FAIL ed_done_count got %0d want 1", done_delta); end
    n_checks++; if (last_err !== 1'b0) begin n_fail++; $display("FAIL ed_err got %b want 0", last_err); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL ed_busy_end got %b want 0", busy_end); end
    n_checks++; if (clk_oe_end !== 1'b0 || data_oe_end !== 1'b0) begin
      n_fail++; $display("FAIL ed_lines_end got clk_oe=%b data_oe=%b want 0 0", clk_oe_end, data_oe_end);
    end
  endtask

  task automatic test_parity;
    xfer(8'h01, 1'b1, 0, 0);
    n_checks++; if (obs[1] !== 1'b0) begin n_fail++; $display("FAIL p01_bit0 data_oe got %b want 0", obs[1]); end
    n_checks++; if (obs[9] !== 1'b1) begin n_fail++; $display("FAIL p01_parity data_oe got %b want 1", obs[9]); end
    xfer(8'h00, 1'b1, 0, 0);
    n_checks++; if (obs[1] !== 1'b1) begin n_fail++; $display("FAIL p00_bit0 data_oe got %b want 1", obs[1]); end
    n_checks++; if (obs[9] !== 1'b0) begin n_fail++; $display("FAIL p00_parity data_oe got %b want 0", obs[9]); end
    n_checks++; if (done_delta != 1 || last_err !== 1'b0) begin
      n_fail++; $display("FAIL p00_done got count=%0d err=%b want 1 0", done_delta, last_err);
    end
  endtask

  task automatic test_nack;
    xfer(8'hED, 1'b0, 0, 0);
    n_checks++; if (obs[11] !== 1'b0) begin n_fail++; $display("FAIL nack_ack_edge data_oe got %b want 0", obs[11]); end
    n_checks++; if (done_delta != 1) begin n_fail++; $display("FAIL nack_done_count got %0d want 1", done_delta); end
    n_checks++; if (last_err !== 1'b1) begin n_fail++; $display("FAIL nack_err got %b want 1", last_err); end
    n_checks++; if (clk_oe_end !== 1'b0 || data_oe_end !== 1'b0) begin
      n_fail++; $display("FAIL nack_lines got clk_oe=%b data_oe=%b want 0 0", clk_oe_end, data_oe_end);
    end
    repeat (10) @(negedge clk);
    n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL nack_err_hold got %b want 1", tx_err); end
  endtask

  task automatic test_ignore_start;
    logic [1:8] exp_bits;
    exp_bits = 8'b00101111;
    xfer(8'hF4, 1'b1, 3, 0);
    n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL ign_err_cleared got %b want 0", err_c1); end
    for (int e = 1; e <= 8; e++) begin
      n_checks++;
      if (obs[e] !== ~exp_bits[e]) begin
        n_fail++; $display("FAIL ign_bit edge %0d data_oe got %b want %b", e, obs[e], ~exp_bits[e]);
      end
    end
    n_checks++; if (obs[9] !== 1'b1) begin n_fail++; $display("FAIL ign_parity data_oe got %b want 1", obs[9]); end
    n_checks++; if (done_delta != 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", done_delta); end
    n_checks++; if (last_err !== 1'b0 || busy_end !== 1'b0) begin
      n_fail++; $display("FAIL ign_end got err=%b busy=%b want 0 0", last_err, busy_end);
    end
  endtask

  task automatic test_abort;
    xfer(8'hED, 1'b1, 0, 5);
    n_checks++; if (obs[5] !== 1'b1) begin n_fail++; $display("FAIL abort_bit4 data_oe got %b want 1", obs[5]); end
    n_checks++; if (ab_clk_oe !== 1'b0) begin n_fail++; $display("FAIL abort_clk_oe got %b want 0", ab_clk_oe); end
    n_checks++; if (ab_data_oe !== 1'b0) begin n_fail++; $display("FAIL abort_data_oe got %b want 0", ab_data_oe); end
    n_checks++; if (ab_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", ab_busy); end
    n_checks++; if (done_delta != 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_delta); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_after got busy=%b want 0", tx_busy); end
  endtask

`ifdef PS2TX_TIMEOUT_EN
  task automatic test_timeout;
    int c;
    @(negedge clk);
    tx_data  = 8'h12;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    c = 1;
    while (!tx_done && c < INH + TO + 50) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL to_done_seen got %b want 1", tx_done); end
    n_checks++; if (c != 1 + INH + TO) begin n_fail++; $display("FAIL to_latency got %0d want %0d", c, 1 + INH + TO); end
    n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", tx_err); end
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++; $display("FAIL to_lines got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_ignore_start();
    test_abort();
`ifdef PS2TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, device-response watchdog limit in clk cycles (15 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock, single clock domain.
REQ-004 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8, byte to send to the PS/2 device.
REQ-006 SHALL have port tx_start, input, 1, one-cycle request that starts a transfer.
REQ-007 SHALL have port tx_busy, output, 1, high while a transfer is in progress.
REQ-008 SHALL have port tx_done, output, 1, one-cycle pulse when a transfer ends.
REQ-009 SHALL have port tx_err, output, 1, error flag valid with tx_done: no ACK or timeout.
REQ-010 SHALL have port ps2_clk_in, input, 1, raw PS/2 clock line level (asynchronous).
REQ-011 SHALL have port ps2_data_in, input, 1, raw PS/2 data line level (asynchronous).
REQ-012 SHALL have port ps2_clk_oe, output, 1, 1 drives the PS/2 clock line low; 0 releases it.
REQ-013 SHALL have port ps2_data_oe, output, 1, 1 drives the PS/2 data line low; 0 releases it.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers and detect a falling edge of the synchronized clock (fall = prev 1, now 0).
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, PARITY, STOP, ACK, WAITIDLE, DONE.
REQ-016 In IDLE, tx_start=1 SHALL latch tx_data, compute odd parity (parity = ~^tx_data), and enter INHIBIT on the next cycle with tx_busy=1.
REQ-017 In INHIBIT, ps2_clk_oe SHALL be 1 for exactly INHIBIT_CYCLES cycles, with ps2_data_oe set to 1 in the last cycle; the block then enters REQ.
REQ-018 In REQ, ps2_clk_oe=0 and ps2_data_oe=1 (start bit); the first falling edge SHALL drive bit0 and enter SHIFT.
REQ-019 In SHIFT, each falling edge SHALL present the next data bit, LSB first, with ps2_data_oe = ~bit; after bit7 is presented, the next falling edge presents parity and enters PARITY.
REQ-020 In PARITY, the next falling edge SHALL release data (stop bit, ps2_data_oe=0) and enter STOP.
REQ-021 In STOP, the next falling edge SHALL sample synchronized data; data=0 means ACK OK, data=1 sets the internal error; the block then enters WAITIDLE.
REQ-022 WAITIDLE SHALL wait until both synchronized lines read 1, then enter DONE.
REQ-023 DONE SHALL last one cycle with tx_done=1 and tx_err=error, then return to IDLE with tx_busy=0.
REQ-024 tx_start SHALL be ignored while tx_busy=1; tx_data SHALL be sampled only at acceptance.
REQ-025 After tx_done, tx_err SHALL hold its value until the next accepted tx_start clears it.
REQ-026 Falling edges seen in IDLE or INHIBIT SHALL be ignored.
REQ-027 Total latency from tx_start to tx_done SHALL be 1 + INHIBIT_CYCLES + device clocking time + 1 cycle.

Reset
REQ-028 While reset=1: state IDLE; tx_busy=0, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0; synchronizers set to 1; counters cleared.
REQ-029 Reset asserted mid-transfer SHALL release both lines on the next clk edge and abort without a tx_done pulse.

Configuration
REQ-030 With macro PS2TX_TIMEOUT_EN defined, a counter SHALL run in states REQ through WAITIDLE, restart on each falling edge, and on reaching TIMEOUT_CYCLES release both lines, set the error, and enter DONE.
REQ-031 Without PS2TX_TIMEOUT_EN, no watchdog logic SHALL exist, and the block waits indefinitely for device clocks.

Verification
REQ-032 Send 0xED with a device model that ACKs: bits on edges 1-8 = 1,0,1,1,0,1,1,1; parity edge 9 = 1; data released at edge 10; one tx_done pulse with tx_err=0.
REQ-033 Send 0x01 -> parity bit 0 observed at edge 9; send 0x00 -> parity bit 1.
REQ-034 Device model leaves data high at edge 11 -> tx_done with tx_err=1; both oe outputs 0 afterwards.
REQ-035 With PS2TX_TIMEOUT_EN, the device never clocks -> tx_done, tx_err=1 at exactly 1+INHIBIT_CYCLES+TIMEOUT_CYCLES cycles after tx_start; lines released.
REQ-036 Pulse tx_start with 0x55 during a 0xF4 transfer -> the pulse is ignored, 0xF4 bits are transmitted, and exactly one tx_done occurs.
REQ-037 Assert reset at edge 5 of a transfer -> next cycle ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, no tx_done.
